apb_lsu_master: RTL and testbench

- Initiator-side load/store unit. Converts one CPU memory-stage request into one APB3 transfer to the peripheral space (UART, GPIO, timers).
- Stalls the pipeline for the duration of the transfer.
- Returns load data already lane-extracted and sign/zero-extended.
- Sits between the MEM stage and the APB interconnect, in parallel with the data memory. The CPU steers a request here when the address decode selects a peripheral.

---
 rtl/apb_lsu_master_if.sv | 37 +++
 rtl/apb_lsu_master.sv | 167 ++++++++++++++++
 tb/tb_apb_lsu_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_lsu_master_if.sv
// Bundle of the CPU-side request/response signals and the APB3 bus seen by
// the peripheral load/store unit.
interface apb_lsu_master_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_strobe;
  logic        req_unsigned;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_strobe, req_unsigned,
    output stall, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_strobe, req_unsigned,
    input  stall, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_lsu_master.sv
// Peripheral load/store unit: turns one MEM-stage request into one APB3
// transfer, stalling the pipeline and returning lane-extracted load data.
module apb_lsu_master #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input logic              clk,
  input logic              rst,
  apb_lsu_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t            state_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              we_r;
  logic [1:0]        size_r;
  logic [1:0]        ofs_r;
  logic              uns_r;
  logic              misaligned_s;

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] s;
    case (size)
      2'd1:    s = 4'b0001 << ofs;
      2'd2:    s = 4'b0011 << {ofs[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'd1:    w = {4{d[7:0]}};
      2'd2:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] ofs,
                                               input logic uns, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (ofs)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = ofs[1] ? d[31:16] : d[15:0];
    case (size)
      2'd1:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd2:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Alignment check of the incoming request
  always_comb begin
    misaligned_s = 1'b0;
    case (bus.req_strobe)
      2'd1:    misaligned_s = 1'b0;
      2'd2:    misaligned_s = bus.req_addr[0];
      default: misaligned_s = (bus.req_addr[1:0] != 2'b00);
    endcase
  end

  assign bus.stall = ((state_r == IDLE) && bus.req_valid) || (state_r == SETUP) || (state_r == ACCESS);

  // Transfer FSM with registered APB and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      to_cnt_r      <= '0;
      we_r          <= 1'b0;
      size_r        <= 2'b00;
      ofs_r         <= 2'b00;
      uns_r         <= 1'b0;
      bus.PADDR     <= 32'd0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PWDATA    <= 32'd0;
      bus.PSTRB     <= 4'b0000;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= 32'd0;
          if (bus.req_valid) begin
            if (misaligned_s) begin
              // Rejected without touching the bus
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              state_r       <= DONE;
            end else begin
              we_r        <= bus.req_we;
              size_r      <= bus.req_strobe;
              ofs_r       <= bus.req_addr[1:0];
              uns_r       <= bus.req_unsigned;
              to_cnt_r    <= '0;
              bus.PADDR   <= {bus.req_addr[31:2], 2'b00};
              bus.PWRITE  <= bus.req_we;
              bus.PWDATA  <= lane_wdata(bus.req_strobe, bus.req_wdata);
              bus.PSTRB   <= bus.req_we ? lane_strb(bus.req_strobe, bus.req_addr[1:0]) : 4'b0000;
              bus.PSEL    <= 1'b1;
              bus.PENABLE <= 1'b0;
              state_r     <= SETUP;
            end
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state_r     <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.PSLVERR;
            bus.rsp_rdata <= (bus.PSLVERR || we_r) ? 32'd0 : load_extract(size_r, ofs_r, uns_r, bus.PRDATA);
            state_r       <= DONE;
          end else if ((TIMEOUT != 0) && (to_cnt_r == TO_LAST)) begin
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= 32'd0;
            state_r       <= DONE;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
          end
        end
        DONE: begin
          // The request still present here is the one just completed
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= 32'd0;
          to_cnt_r      <= '0;
          state_r       <= IDLE;
        end
        default: begin
          bus.PSEL    <= 1'b0;
          bus.PENABLE <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_lsu_master.sv
// Directed, table-driven bench for apb_lsu_master plus hand sequences for
// timeout and mid-transfer reset.
module tb_apb_lsu_master;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cur_idx;

  apb_lsu_master_if bus ();

  apb_lsu_master #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  strobe;
    logic        uns;
    logic [31:0] prdata;
    logic        slverr;
    int          delay;
    logic        apb;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s [case %0d]: got 0x%08h, expected 0x%08h", nm, cur_idx, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   stalls;
    logic ok;
    stalls = 0;
    ok     = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_strobe   = v.strobe;
    bus.req_unsigned = v.uns;
    bus.PRDATA       = v.prdata;
    bus.PSLVERR      = v.slverr;
    bus.PREADY       = 1'b0;
    #1;
    if (bus.stall) stalls++;
    @(posedge clk); @(negedge clk);
    if (v.apb) begin
      if (bus.stall) stalls++;
      chk("setup_psel",    {31'd0, bus.PSEL},    32'd1);
      chk("setup_penable", {31'd0, bus.PENABLE}, 32'd0);
      chk("setup_paddr",   bus.PADDR,            v.paddr);
      chk("setup_pwrite",  {31'd0, bus.PWRITE},  {31'd0, v.pwrite});
      chk("setup_pwdata",  bus.PWDATA,           v.pwdata);
      chk("setup_pstrb",   {28'd0, bus.PSTRB},   {28'd0, v.pstrb});
      for (int k = 0; k <= v.delay; k++) begin
        @(posedge clk); @(negedge clk);
        if (bus.stall) stalls++;
        if (!(bus.PSEL && bus.PENABLE && bus.PADDR == v.paddr && bus.PWDATA == v.pwdata &&
              bus.PSTRB == v.pstrb && bus.PWRITE == v.pwrite && !bus.rsp_valid)) ok = 1'b0;
        bus.PREADY = (k == v.delay);
      end
      chk("access_stable", {31'd0, ok}, 32'd1);
      @(posedge clk); @(negedge clk);
      bus.PREADY = 1'b0;
    end
    chk("done_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("done_rsp_err",   {31'd0, bus.rsp_err},   {31'd0, v.err});
    chk("done_rsp_rdata", bus.rsp_rdata,          v.rdata);
    chk("done_bus_idle",  {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("done_stall",     {31'd0, bus.stall},     32'd0);
    chk("stall_cycles",   stalls,                 v.apb ? (3 + v.delay) : 1);
    @(posedge clk); @(negedge clk);
    chk("no_reaccept", {30'd0, bus.PSEL, bus.rsp_valid}, 32'd0);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cur_idx  = -1;
    //          we    addr          wdata         sz    uns   prdata        serr dly apb  paddr         pw    pwdata        pstrb    rdata         err
    vecs[0]  = '{1'b0, 32'h0000_1004, 32'h0000_0000, 2'd3, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1, 32'h0000_1004, 1'b0, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, 32'h4000_0003, 32'h0000_00A5, 2'd1, 1'b0, 32'h0000_0000, 1'b0, 0, 1'b1, 32'h4000_0000, 1'b1, 32'hA5A5_A5A5, 4'b1000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h4000_0102, 32'h0000_0000, 2'd2, 1'b0, 32'h8001_1234, 1'b0, 0, 1'b1, 32'h4000_0100, 1'b0, 32'h0000_0000, 4'b0000, 32'hFFFF_8001, 1'b0};
    vecs[3]  = '{1'b0, 32'h4000_0102, 32'h0000_0000, 2'd2, 1'b1, 32'h8001_1234, 1'b0, 0, 1'b1, 32'h4000_0100, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_8001, 1'b0};
    vecs[4]  = '{1'b1, 32'h4000_0202, 32'h1234_BEEF, 2'd2, 1'b0, 32'h0000_0000, 1'b0, 1, 1'b1, 32'h4000_0200, 1'b1, 32'hBEEF_BEEF, 4'b1100, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h4000_0301, 32'h0000_0000, 2'd1, 1'b0, 32'h1122_8344, 1'b0, 0, 1'b1, 32'h4000_0300, 1'b0, 32'h0000_0000, 4'b0000, 32'hFFFF_FF83, 1'b0};
    vecs[6]  = '{1'b0, 32'h4000_0302, 32'h0000_0000, 2'd1, 1'b1, 32'h119A_8344, 1'b0, 0, 1'b1, 32'h4000_0300, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_009A, 1'b0};
    vecs[7]  = '{1'b1, 32'h2000_0008, 32'hCAFE_F00D, 2'd3, 1'b0, 32'h0000_0000, 1'b0, 3, 1'b1, 32'h2000_0008, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h2000_0010, 32'h0000_0000, 2'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 2, 1'b1, 32'h2000_0010, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h2000_0012, 32'h0000_0000, 2'd0, 1'b0, 32'h0000_0000, 1'b0, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 32'h2000_0021, 32'h0000_FFFF, 2'd2, 1'b0, 32'h0000_0000, 1'b0, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'h4000_000F, 32'h0000_0000, 2'd1, 1'b0, 32'h7F00_0000, 1'b0, 0, 1'b1, 32'h4000_000C, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_007F, 1'b0};
    vecs[12] = '{1'b0, 32'h4000_0400, 32'h0000_0000, 2'd0, 1'b1, 32'h1234_5678, 1'b0, 1, 1'b1, 32'h4000_0400, 1'b0, 32'h0000_0000, 4'b0000, 32'h1234_5678, 1'b0};

    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.req_strobe   = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.PRDATA       = 32'd0;
    bus.PREADY       = 1'b0;
    bus.PSLVERR      = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_psel_penable", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("rst_rsp",          {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    chk("rst_paddr",        bus.PADDR, 32'd0);
    chk("rst_stall",        {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      cur_idx = i;
      run_vec(vecs[i]);
    end

    // Slave never ready: abort after 16 ACCESS cycles
    begin
      logic ok;
      ok      = 1'b1;
      cur_idx = 100;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h3000_0040;
      bus.req_strobe = 2'd3;
      bus.PREADY     = 1'b0;
      bus.PSLVERR    = 1'b0;
      bus.PRDATA     = 32'h5555_AAAA;
      @(posedge clk); @(negedge clk);
      chk("to_setup_psel", {31'd0, bus.PSEL}, 32'd1);
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); @(negedge clk);
        if (!(bus.PSEL && bus.PENABLE && bus.stall && !bus.rsp_valid)) ok = 1'b0;
      end
      chk("to_access_16", {31'd0, ok}, 32'd1);
      @(posedge clk); @(negedge clk);
      chk("to_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("to_rsp_err",   {31'd0, bus.rsp_err},   32'd1);
      chk("to_rsp_rdata", bus.rsp_rdata,          32'd0);
      chk("to_psel",      {31'd0, bus.PSEL},      32'd0);
      bus.req_valid = 1'b0;
      @(negedge clk);
    end

    // Reset during ACCESS drops the bus immediately and produces no response
    begin
      logic ok;
      ok      = 1'b1;
      cur_idx = 101;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h3000_0010;
      bus.req_strobe = 2'd3;
      bus.PREADY     = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("rstmid_in_access", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
      #2;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      #1;
      chk("rstmid_async_drop", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
      bus.PREADY = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      bus.PREADY = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); @(negedge clk);
        if (bus.rsp_valid || bus.PSEL) ok = 1'b0;
      end
      chk("rstmid_no_rsp", {31'd0, ok}, 32'd1);
    end

    cur_idx = 0;
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
